// File: rtl/snoop_dcache_if.sv
// Datapath and coherence-bus signals of one snooping data cache.
// The cache takes the slave side; the datapath/controller side is master.
interface snoop_dcache_if;
   logic        dmemREN, dmemWEN, dhit;
   logic [31:0] dmemaddr, dmemstore, dmemload;
   logic        dREN, dWEN, dwait;
   logic [31:0] daddr, dstore, dload;
   logic        ccwrite, cctrans, ccwait, ccinv;
   logic [31:0] ccsnoopaddr;

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
             ccwait, ccinv, ccsnoopaddr,
      output dmemload, dhit, dREN, dWEN, daddr, dstore, ccwrite, cctrans
   );

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
             ccwait, ccinv, ccsnoopaddr,
      input  dmemload, dhit, dREN, dWEN, daddr, dstore, ccwrite, cctrans
   );
endinterface

// File: rtl/snoop_dcache.sv
// Direct-mapped MSI data cache with two-word blocks and a snoop agent.
// Misses write back an M victim, refetch as S, and stores upgrade via ccwrite.
module snoop_dcache #(
   parameter int SETS = 8
) (
   input logic           CLK,
   input logic           nRST,
   snoop_dcache_if.slave dif
);
   localparam int IW = $clog2(SETS);
   localparam int TW = 29 - IW;

   typedef enum logic [2:0] {IDLE, WB0, WB1, FETCH0, FETCH1, UPGRADE} state_t;
   state_t state, nstate;

   logic [SETS-1:0] valid, dirty;
   logic [TW-1:0]   tags [SETS];
   logic [31:0]     data [SETS][2];

   logic [TW-1:0] rtag, stag;
   logic [IW-1:0] ridx, sidx, sidx_q;
   logic          rhit, whit, victim_m, snp_hit, grant, bus_done;
   logic          ccwait_q, snp_m_q, dhit;
   logic [31:0]   wbdata;
   logic          unused_bits;

   assign rtag     = dif.dmemaddr[31:IW+3];
   assign ridx     = dif.dmemaddr[IW+2:3];
   assign stag     = dif.ccsnoopaddr[31:IW+3];
   assign sidx     = dif.ccsnoopaddr[IW+2:3];
   assign rhit     = valid[ridx] & (tags[ridx] == rtag);
   assign whit     = rhit & dirty[ridx];
   assign victim_m = valid[ridx] & dirty[ridx];
   assign snp_hit  = valid[sidx] & (tags[sidx] == stag);
   assign bus_done = ~dif.dwait;
   // A matching invalidate while we are asking to upgrade is our own grant.
   assign grant    = (state == UPGRADE) & dif.ccinv &
                     (dif.ccsnoopaddr[31:3] == dif.dmemaddr[31:3]);
   assign unused_bits = ^{dif.dmemaddr[1:0], dif.ccsnoopaddr[1:0]};

   always_comb begin
      nstate      = state;
      dhit        = 1'b0;
      dif.dREN    = 1'b0;
      dif.dWEN    = 1'b0;
      dif.ccwrite = 1'b0;
      dif.daddr   = '0;
      wbdata      = '0;
      case (state)
         IDLE: begin
            if (dif.dmemWEN) begin
               if (whit)          dhit   = 1'b1;
               else if (rhit)     nstate = UPGRADE;
               else if (victim_m) nstate = WB0;
               else               nstate = FETCH0;
            end else if (dif.dmemREN) begin
               if (rhit)          dhit   = 1'b1;
               else if (victim_m) nstate = WB0;
               else               nstate = FETCH0;
            end
         end
         WB0: begin
            dif.dWEN  = 1'b1;
            dif.daddr = {tags[ridx], ridx, 3'b000};
            wbdata    = data[ridx][0];
            if (bus_done) nstate = WB1;
         end
         WB1: begin
            dif.dWEN  = 1'b1;
            dif.daddr = {tags[ridx], ridx, 3'b100};
            wbdata    = data[ridx][1];
            if (bus_done) nstate = FETCH0;
         end
         FETCH0: begin
            dif.dREN  = 1'b1;
            dif.daddr = {rtag, ridx, 3'b000};
            if (bus_done) nstate = FETCH1;
         end
         FETCH1: begin
            dif.dREN  = 1'b1;
            dif.daddr = {rtag, ridx, 3'b100};
            if (bus_done) nstate = IDLE;
         end
         UPGRADE: begin
            dif.ccwrite = 1'b1;
            dif.daddr   = {dif.dmemaddr[31:3], 3'b000};
            if (grant)      nstate = IDLE;
            else if (!rhit) nstate = FETCH0;
         end
         default: nstate = IDLE;
      endcase
   end

   assign dif.dhit     = dhit;
   assign dif.dmemload = dhit ? data[ridx][dif.dmemaddr[2]] : '0;
   assign dif.dstore   = dif.ccwait ? data[sidx][dif.ccsnoopaddr[2]] : wbdata;
   assign dif.cctrans  = dif.ccwait & snp_hit & dirty[sidx];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         valid    <= '0;
         dirty    <= '0;
         ccwait_q <= 1'b0;
         snp_m_q  <= 1'b0;
         sidx_q   <= '0;
         for (int i = 0; i < SETS; i++) begin
            tags[i]    <= '0;
            data[i][0] <= '0;
            data[i][1] <= '0;
         end
      end else begin
         state    <= nstate;
         ccwait_q <= dif.ccwait;
         if (dif.ccwait && !ccwait_q) begin
            sidx_q  <= sidx;
            snp_m_q <= snp_hit & dirty[sidx];
         end
         // Controller has taken the supplied block into memory: M drops to S.
         if (!dif.ccwait && ccwait_q && snp_m_q) dirty[sidx_q] <= 1'b0;
         if (dif.ccinv && !grant && snp_hit) begin
            valid[sidx] <= 1'b0;
            dirty[sidx] <= 1'b0;
         end
         // Later assignments win, so a completing fetch overrides an invalidate.
         case (state)
            IDLE:    if (dhit && dif.dmemWEN) data[ridx][dif.dmemaddr[2]] <= dif.dmemstore;
            WB1:     if (bus_done) dirty[ridx] <= 1'b0;
            FETCH0:  if (bus_done) data[ridx][0] <= dif.dload;
            FETCH1:  if (bus_done) begin
                        data[ridx][1] <= dif.dload;
                        valid[ridx]   <= 1'b1;
                        dirty[ridx]   <= 1'b0;
                        tags[ridx]    <= rtag;
                     end
            UPGRADE: if (grant) dirty[ridx] <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_snoop_dcache.sv
// Bench for snoop_dcache: a memory/controller responder plus a line-state
// model that predicts every bus transaction and every loaded word.
module tb_snoop_dcache;
   logic CLK = 1'b0;
   logic nRST;
   snoop_dcache_if bus();

   snoop_dcache #(.SETS(8)) dut (.CLK(CLK), .nRST(nRST), .dif(bus.slave));

   always #5 CLK = ~CLK;

   typedef struct {
      int          kind;   // 1 fetch, 2 write-back, 3 upgrade
      logic [31:0] addr;
      logic [31:0] data;
   } op_t;

   int          n_pass = 0;
   int          n_tot  = 0;
   logic [31:0] mem   [256];
   logic [31:0] truth [256];
   bit          m_valid [8];
   bit          m_dirty [8];
   int          m_tag   [8];
   op_t         expq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   task automatic push_op(input int k, input logic [31:0] a, input logic [31:0] d);
      op_t o;
      o.kind = k; o.addr = a; o.data = d;
      expq.push_back(o);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0;
      end
      for (int i = 0; i < 256; i++) truth[i] = mem[i];
   endtask

   // Predict the bus traffic of one access, then drive it and act as controller.
   task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d);
      int          idx, tg, cyc, stall, k;
      bit          hit, done, started;
      logic [31:0] base, vb;
      idx  = int'(a[5:3]);
      tg   = int'(a[31:6]);
      base = {a[31:3], 3'b000};
      hit  = m_valid[idx] && (m_tag[idx] == tg);
      expq.delete();
      if (!(hit && (m_dirty[idx] || !we))) begin
         if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
               vb = 32'(m_tag[idx]) * 64 + 32'(idx) * 8;
               push_op(2, vb, truth[widx(vb)]);
               push_op(2, vb + 4, truth[widx(vb + 4)]);
            end
            push_op(1, base, 0);
            push_op(1, base + 4, 0);
         end
         if (we) push_op(3, base, 0);
      end
      m_valid[idx] = 1; m_tag[idx] = tg;
      if (we) begin
         m_dirty[idx] = 1;
      end else if (!hit) begin
         m_dirty[idx] = 0;
      end

      bus.dmemREN = !we; bus.dmemWEN = we; bus.dmemaddr = a; bus.dmemstore = d;
      done = 0; started = 0; stall = 0; cyc = 0;
      while (!done && cyc < 200) begin
         @(negedge CLK);
         cyc++;
         bus.dwait = 1'b1; bus.ccinv = 1'b0;
         if (bus.dhit) begin
            chk("pending_ops_at_hit", 32'(expq.size()), 0);
            if (!we) chk("load_data", bus.dmemload, truth[widx(a)]);
            done = 1;
         end else if (bus.dREN || bus.dWEN || bus.ccwrite) begin
            chk("single_request", 32'(int'(bus.dREN) + int'(bus.dWEN) + int'(bus.ccwrite)), 1);
            k = bus.dREN ? 1 : (bus.dWEN ? 2 : 3);
            if (!started) begin
               started = 1;
               stall = $urandom_range(0, 2);
               if (expq.size() == 0) begin
                  chk("unexpected_op_kind", 32'(k), 0);
               end else begin
                  chk("op_kind", 32'(k), 32'(expq[0].kind));
                  chk("op_addr", bus.daddr, expq[0].addr);
                  if (k == 2) chk("wb_data", bus.dstore, expq[0].data);
               end
            end
            if (stall > 0) begin
               stall--;
            end else begin
               if (k == 1) begin
                  bus.dwait = 1'b0; bus.dload = mem[widx(bus.daddr)];
               end else if (k == 2) begin
                  bus.dwait = 1'b0; mem[widx(bus.daddr)] = bus.dstore;
               end else begin
                  bus.ccinv = 1'b1; bus.ccsnoopaddr = bus.daddr;
               end
               if (expq.size() != 0) void'(expq.pop_front());
               started = 0;
            end
         end
      end
      if (!done) chk("access_timeout", 0, 1);
      if (we) truth[widx(a)] = d;
      @(posedge CLK);
      #1;
      bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.dwait = 1'b1; bus.ccinv = 1'b0;
   endtask

   // Controller snoop: supply if M, then optionally invalidate.
   task automatic snoop(input logic [31:0] a, input bit inv);
      int idx, tg;
      bit hit, m;
      idx = int'(a[5:3]);
      tg  = int'(a[31:6]);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      m   = hit && m_dirty[idx];
      @(negedge CLK);
      bus.ccwait = 1'b1; bus.ccsnoopaddr = a;
      #1;
      chk("cctrans", 32'(bus.cctrans), 32'(m));
      if (m) begin
         chk("snoop_dstore", bus.dstore, truth[widx(a)]);
         mem[widx({a[31:3], 3'b000})] = truth[widx({a[31:3], 3'b000})];
         mem[widx({a[31:3], 3'b100})] = truth[widx({a[31:3], 3'b100})];
         m_dirty[idx] = 0;
      end
      @(negedge CLK);
      bus.ccwait = 1'b0;
      if (inv) bus.ccinv = 1'b1;
      @(negedge CLK);
      bus.ccinv = 1'b0;
      if (inv && hit) begin
         m_valid[idx] = 0; m_dirty[idx] = 0;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ctl"}, 32'({bus.dhit, bus.dREN, bus.dWEN, bus.ccwrite, bus.cctrans}), 0);
      chk({tag, "_daddr"}, bus.daddr, 0);
      chk({tag, "_dstore"}, bus.dstore, 0);
      chk({tag, "_dmemload"}, bus.dmemload, 0);
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      model_reset();
      bus.dmemREN = 0; bus.dmemWEN = 0; bus.dmemaddr = 0; bus.dmemstore = 0;
      bus.dload = 0; bus.dwait = 1; bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;
      nRST = 1'b0;
      #1;
      check_outputs_zero("reset");
      repeat (2) @(negedge CLK);
      nRST = 1'b1;

      // Reset while the second word of a fetch is outstanding.
      @(negedge CLK);
      bus.dmemREN = 1'b1; bus.dmemaddr = 32'h68;
      @(negedge CLK);
      chk("rst_f0_dren", 32'(bus.dREN), 1);
      chk("rst_f0_addr", bus.daddr, 32'h68);
      bus.dwait = 1'b0; bus.dload = mem[widx(32'h68)];
      @(negedge CLK);
      bus.dwait = 1'b1;
      chk("rst_f1_addr", bus.daddr, 32'h6C);
      nRST = 1'b0;
      #1;
      check_outputs_zero("midfetch_reset");
      @(negedge CLK);
      bus.dmemREN = 1'b0;
      nRST = 1'b1;
      model_reset();
      access(0, 32'h68, 0);

      // Directed MSI walk on set 0.
      access(0, 32'h40, 0);
      access(1, 32'h44, 32'hDEAD);
      access(0, 32'h44, 0);
      access(0, 32'h240, 0);
      access(1, 32'h44, 32'hBEEF);
      snoop(32'h44, 0);
      access(1, 32'h40, 32'h1234);
      snoop(32'h40, 0);
      @(negedge CLK);
      bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h40;
      @(negedge CLK);
      bus.ccinv = 1'b0;
      m_valid[0] = 0; m_dirty[0] = 0;
      access(0, 32'h40, 0);

      // Random mix over four tags so sets conflict often.
      for (int n = 0; n < 400; n++) begin
         a = {22'b0, 2'(unsigned'($urandom_range(0, 3))), 3'(unsigned'($urandom_range(0, 7))),
              1'(unsigned'($urandom_range(0, 1))), 2'b00};
         r = $urandom_range(0, 9);
         if (r < 5)      access(0, a, 0);
         else if (r < 8) access(1, a, $urandom);
         else            snoop(a, r == 9);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/snoop_dcache.md
# snoop_dcache

Per-core coherent data cache and snoop agent on the coherence bus side of the memory controller. It serves the datapath's load and store requests. On misses it issues two-word block fetches and write-backs toward the controller, and requests S→M upgrades with `ccwrite`. It answers the controller's snoops by supplying modified blocks (`cctrans`/`dstore`) and by invalidating lines on `ccinv`. It implements MSI over a direct-mapped array of 8 two-word blocks.

## Interface
- `SETS`, 8: number of direct-mapped sets (index width = log2(SETS) = 3).
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `dmemREN` in 1: datapath load request.
- `dmemWEN` in 1: datapath store request.
- `dmemaddr` in 32: word address. Fields: tag [31:6], index [5:3], block offset [2], byte [1:0] ignored.
- `dmemstore` in 32: store data.
- `dmemload` out 32: load data, valid when `dhit`.
- `dhit` out 1: request satisfied this cycle.
- `dREN` out 1: block fetch request to controller.
- `dWEN` out 1: word write-back request to controller.
- `daddr` out 32: word address of the current bus word.
- `dstore` out 32: write-back data, or snoop-supply data while `ccwait`.
- `dload` in 32: fetched word, valid when `dwait`=0.
- `dwait` in 1: 0 means the current bus word completes this cycle.
- `ccwrite` out 1: upgrade (S→M) request, with `daddr` = block base.
- `cctrans` out 1: snooped block is held Modified and is supplied by this cache.
- `ccwait` in 1: this cache is being snooped.
- `ccinv` in 1: invalidate the block at `ccsnoopaddr`. While `ccwrite`=1 and the addresses match, it is the upgrade grant instead.
- `ccsnoopaddr` in 32: snooped word address.

## Operation
- Per set: valid, dirty, tag[25:0], data[2][32]. Line state encoding: I = !valid; S = valid & !dirty; M = valid & dirty.
- Hit conditions:
  - Read hit: valid & tag match.
  - Write hit: valid & dirty & tag match.
  - On write hit: the word is written and M is kept.
- FSM states: IDLE, WB0, WB1, FETCH0, FETCH1, UPGRADE.
- IDLE:
  - Hit: `dhit`=1, stay.
  - Write to an S line with matching tag: go to UPGRADE.
  - Other miss, victim M: go to WB0.
  - Other miss, victim not M: go to FETCH0.
- WB0/WB1:
  - `dWEN`=1, `daddr` = {victim tag, index, 0/1, 00}, `dstore` = the corresponding victim word.
  - Advance on `dwait`=0. WB1 exits to FETCH0 and clears the dirty bit.
- FETCH0/FETCH1:
  - `dREN`=1, `daddr` = {req tag, index, 0/1, 00}.
  - On `dwait`=0: write `dload` into word 0/1. FETCH1 then sets valid=1, dirty=0, tag = request tag, and returns to IDLE.
  - `dREN` drops in the cycle after FETCH1 completes.
  - A store miss therefore refetches as S and then upgrades.
- UPGRADE:
  - `ccwrite`=1, `daddr` = block base.
  - On `ccinv`=1 with `ccsnoopaddr`[31:3] matching: set dirty=1 and return to IDLE, where the store hits next cycle.
  - If a foreign invalidate of this line arrives first (`ccinv` with `ccwrite` and a different or stale match sequence, i.e. line becomes invalid), go to FETCH0.
- Snoop (any state, combinational):
  - `cctrans` = `ccwait` & snoop hit & dirty.
  - While `ccwait`=1, `dstore` = data[`ccsnoopaddr`[2]] of the snooped set.
- Supplier latch:
  - On the first `ccwait` cycle (rising edge), latch the snooped index and whether it hit M.
  - When `ccwait` falls, if the latched hit was M: clear dirty (M→S). Memory was written by the controller.
- `ccinv` without a matching `ccwrite` grant, on a tag match: valid=0, dirty=0.
- Simultaneous events:
  - A snoop invalidate of the set currently in FETCH is harmless; the fetch overwrites the set.
  - A snoop of an M victim during WB supplies the same data.
- Reset clears all valid/dirty bits and returns the FSM to IDLE.
- All outputs reset to 0: `dhit`, `dREN`, `dWEN`, `ccwrite`, `cctrans`, `daddr`, `dstore`, `dmemload`.

## Timing
- Hit latency: 0 cycles (`dhit` combinational in IDLE).
- Clean miss: request asserted the cycle after the miss, plus two bus word completions, plus 1 cycle to hit.
- Dirty miss: two additional write-back words before the fetch.
- `dREN`/`dWEN`/`ccwrite` are held stable until the completing `dwait`=0 or `ccinv`.
- The cache never asserts two of `dREN`/`dWEN`/`ccwrite` together.
- Reset mid-transaction: outputs drop immediately (asynchronous). Line contents are discarded.

## Test plan
- Cold read of 0x40: FETCH0/FETCH1 with `daddr` 0x40 then 0x44. After the second `dwait`=0, `dhit`=1 and `dmemload` = the fetched word.
- Store 0xDEAD to 0x44 after the cold read: `ccwrite`=1 with `daddr`=0x40. The `ccinv` grant follows, then `dhit`=1, and a reload of 0x44 returns 0xDEAD.
- Line 0x40 held M, then a read of 0x240 (same set): WB `dWEN` of 0x40 and 0x44 with the old data, then a fetch of 0x240/0x244.
- Snoop with `ccwait`=1, `ccsnoopaddr`=0x44 on an M line: `cctrans`=1 the same cycle and `dstore` = word 1. After `ccwait` falls the line is S, and a following store requires an upgrade.
- Foreign invalidate: `ccinv`=1 with `ccsnoopaddr`=0x40 while the line is S and this cache is idle. The next read of 0x40 misses (`dREN`=1).
- Reset asserted during FETCH1: all outputs 0 immediately. After release, a read of the same address misses.
